// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM encoding,
// operation/register selectors and the default watchdog length.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LAUNCH    = 2'b01,
    ST_WAIT_MULT = 2'b10,
    ST_WAIT_DIV  = 2'b11
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam logic HILO_LO = 1'b0;
  localparam logic HILO_HI = 1'b1;

  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Bundle of control-unit requests, multiplier/divider handshakes and HI/LO
// results; the sequencer takes the slave side.
interface muldiv_ctrl_if;

  logic        op_start;
  logic        op_sel;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  logic        mult_ctrl;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic        mult_end;

  logic        div_ctrl;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        div_end;

  logic        hilo_wr;
  logic        hilo_sel;
  logic [31:0] hilo_wdata;

  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        timeout_err;

  modport slave (
    input  op_start, op_sel, rs_val, rt_val,
    input  mult_hi, mult_lo, mult_end,
    input  div_hi, div_lo, div_end,
    input  hilo_wr, hilo_sel, hilo_wdata,
    output mult_ctrl, mult_a, mult_b,
    output div_ctrl, div_a, div_b,
    output hi, lo, busy, done, div_zero, timeout_err
  );

  modport master (
    output op_start, op_sel, rs_val, rt_val,
    output mult_hi, mult_lo, mult_end,
    output div_hi, div_lo, div_end,
    output hilo_wr, hilo_sel, hilo_wdata,
    input  mult_ctrl, mult_a, mult_b,
    input  div_ctrl, div_a, div_b,
    input  hi, lo, busy, done, div_zero, timeout_err
  );

endinterface

// File: rtl/hilo_regs.sv
// Architectural HI/LO pair. A unit commit writes both registers and wins
// over a single-register MTHI/MTLO write in the same cycle.
module hilo_regs
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_commit,
  input  logic [31:0] i_commit_hi,
  input  logic [31:0] i_commit_lo,
  input  logic        i_wr,
  input  logic        i_wr_sel,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_commit) begin
      r_hi <= i_commit_hi;
      r_lo <= i_commit_lo;
    end else if (i_wr) begin
      case (i_wr_sel)
        HILO_HI: r_hi <= i_wdata;
        HILO_LO: r_lo <= i_wdata;
        default: ;
      endcase
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer that launches one MULT/DIV at a time, waits for the unit's end
// flag under a watchdog, and commits the result into HI/LO.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_mult_ctrl, w_mult_ctrl_nxt;
  logic          r_div_ctrl, w_div_ctrl_nxt;
  logic          r_done, w_done_nxt;
  logic          r_div_zero, w_div_zero_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic [31:0]   r_mult_a, r_mult_b, r_div_a, r_div_b;
  logic          w_latch_mult, w_latch_div, w_commit, w_end, w_hilo_we;
  logic [31:0]   w_commit_hi, w_commit_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Only the unit that was launched is listened to; a stale end from an
  // earlier operation cannot be seen here because end is read in WAIT only.
  assign w_end       = (r_state == ST_WAIT_DIV) ? bus.div_end : bus.mult_end;
  assign w_commit_hi = (r_state == ST_WAIT_DIV) ? bus.div_hi  : bus.mult_hi;
  assign w_commit_lo = (r_state == ST_WAIT_DIV) ? bus.div_lo  : bus.mult_lo;

  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_busy_nxt      = r_busy;
    w_mult_ctrl_nxt = 1'b0;
    w_div_ctrl_nxt  = 1'b0;
    w_done_nxt      = 1'b0;
    w_div_zero_nxt  = 1'b0;
    w_timeout_nxt   = 1'b0;
    w_latch_mult    = 1'b0;
    w_latch_div     = 1'b0;
    w_commit        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.op_start) begin
          if (bus.op_sel == OP_DIV) begin
            if (bus.rt_val == '0) begin
              w_div_zero_nxt = 1'b1;
            end else begin
              w_latch_div    = 1'b1;
              w_div_ctrl_nxt = 1'b1;
              w_busy_nxt     = 1'b1;
              w_state_nxt    = ST_LAUNCH;
            end
          end else begin
            w_latch_mult    = 1'b1;
            w_mult_ctrl_nxt = 1'b1;
            w_busy_nxt      = 1'b1;
            w_state_nxt     = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        w_state_nxt = r_div_ctrl ? ST_WAIT_DIV : ST_WAIT_MULT;
        w_count_nxt = '0;
      end
      ST_WAIT_MULT, ST_WAIT_DIV: begin
        if (w_end) begin
          w_commit    = 1'b1;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (r_count == CNT_LAST) begin
          w_timeout_nxt = 1'b1;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_mult_ctrl <= 1'b0;
      r_div_ctrl  <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_busy      <= w_busy_nxt;
      r_mult_ctrl <= w_mult_ctrl_nxt;
      r_div_ctrl  <= w_div_ctrl_nxt;
      r_done      <= w_done_nxt;
      r_div_zero  <= w_div_zero_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mult_a <= '0;
      r_mult_b <= '0;
      r_div_a  <= '0;
      r_div_b  <= '0;
    end else begin
      if (w_latch_mult) begin
        r_mult_a <= bus.rs_val;
        r_mult_b <= bus.rt_val;
      end
      if (w_latch_div) begin
        r_div_a <= bus.rs_val;
        r_div_b <= bus.rt_val;
      end
    end
  end

  // MTHI/MTLO is gated by the registered stall, so it still lands in the
  // same cycle as a new op_start.
  assign w_hilo_we = bus.hilo_wr & ~r_busy;

  hilo_regs u_hilo (
    .clk         (clk),
    .rst         (rst),
    .i_commit    (w_commit),
    .i_commit_hi (w_commit_hi),
    .i_commit_lo (w_commit_lo),
    .i_wr        (w_hilo_we),
    .i_wr_sel    (bus.hilo_sel),
    .i_wdata     (bus.hilo_wdata),
    .o_hi        (bus.hi),
    .o_lo        (bus.lo)
  );

  assign bus.mult_ctrl   = r_mult_ctrl;
  assign bus.mult_a      = r_mult_a;
  assign bus.mult_b      = r_mult_b;
  assign bus.div_ctrl    = r_div_ctrl;
  assign bus.div_a       = r_div_a;
  assign bus.div_b       = r_div_b;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_zero    = r_div_zero;
  assign bus.timeout_err = r_timeout;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: behavioural 32-step multiplier and
// 10-step divider on one instance, a stuck-unit instance with TIMEOUT = 8.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_ctrl_if b1 ();
  muldiv_ctrl_if b2 ();

  muldiv_ctrl #(.TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  muldiv_ctrl #(.TIMEOUT(8)) dut_to (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  int checks   = 0;
  int failures = 0;
  int mult_pulses = 0;
  int div_pulses  = 0;
  int busy_cycles = 0;
  int cyc;

  // Units for the second instance never finish.
  assign b2.mult_hi  = 32'h0BAD_0BAD;
  assign b2.mult_lo  = 32'h0BAD_0BAD;
  assign b2.mult_end = 1'b0;
  assign b2.div_hi   = 32'h0BAD_0BAD;
  assign b2.div_lo   = 32'h0BAD_0BAD;
  assign b2.div_end  = 1'b0;

  logic               m_run;
  int                 m_cnt;
  logic signed [63:0] m_prod;

  // 32-step multiplier: start seen at E1, end rises after E32 and stays high.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run       <= 1'b0;
      m_cnt       <= 0;
      m_prod      <= '0;
      b1.mult_end <= 1'b0;
      b1.mult_hi  <= '0;
      b1.mult_lo  <= '0;
    end else if (b1.mult_ctrl) begin
      m_run       <= 1'b1;
      m_cnt       <= 1;
      b1.mult_end <= 1'b0;
      m_prod      <= $signed({{32{b1.mult_a[31]}}, b1.mult_a}) *
                     $signed({{32{b1.mult_b[31]}}, b1.mult_b});
    end else if (m_run) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 31) begin
        m_run       <= 1'b0;
        b1.mult_end <= 1'b1;
        {b1.mult_hi, b1.mult_lo} <= m_prod;
      end
    end
  end

  logic               d_run;
  int                 d_cnt;
  logic signed [31:0] d_q, d_r;

  // 10-step divider: end rises after E10; hi = remainder, lo = quotient.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d_run      <= 1'b0;
      d_cnt      <= 0;
      d_q        <= '0;
      d_r        <= '0;
      b1.div_end <= 1'b0;
      b1.div_hi  <= '0;
      b1.div_lo  <= '0;
    end else if (b1.div_ctrl) begin
      d_run      <= 1'b1;
      d_cnt      <= 1;
      b1.div_end <= 1'b0;
      d_q        <= $signed(b1.div_a) / $signed(b1.div_b);
      d_r        <= $signed(b1.div_a) % $signed(b1.div_b);
    end else if (d_run) begin
      d_cnt <= d_cnt + 1;
      if (d_cnt == 9) begin
        d_run      <= 1'b0;
        b1.div_end <= 1'b1;
        b1.div_hi  <= d_r;
        b1.div_lo  <= d_q;
      end
    end
  end

  always @(negedge clk) begin
    if (b1.mult_ctrl) mult_pulses++;
    if (b1.div_ctrl)  div_pulses++;
    if (b1.busy)      busy_cycles++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Returns in cycle E0->E1 of the new operation.
  task automatic start_op(input logic sel, input logic [31:0] a, input logic [31:0] b);
    step();
    mult_pulses = 0;
    div_pulses  = 0;
    busy_cycles = 0;
    b1.op_start = 1'b1;
    b1.op_sel   = sel;
    b1.rs_val   = a;
    b1.rt_val   = b;
    step();
    b1.op_start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!b1.done && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b1.op_start = 0; b1.op_sel = 0; b1.rs_val = 0; b1.rt_val = 0;
    b1.hilo_wr = 0; b1.hilo_sel = 0; b1.hilo_wdata = 0;
    b2.op_start = 0; b2.op_sel = 0; b2.rs_val = 0; b2.rt_val = 0;
    b2.hilo_wr = 0; b2.hilo_sel = 0; b2.hilo_wdata = 0;
    repeat (2) step();
    checks++;
    if ({b1.busy, b1.mult_ctrl, b1.div_ctrl, b1.done, b1.div_zero, b1.timeout_err} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b exp=000000",
               {b1.busy, b1.mult_ctrl, b1.div_ctrl, b1.done, b1.div_zero, b1.timeout_err});
    end
    checks++;
    if ({b1.hi, b1.lo} !== 64'h0) begin
      failures++;
      $display("[TB] FAIL reset_hilo got=%h_%h exp=0", b1.hi, b1.lo);
    end
    checks++;
    if ({b1.mult_a, b1.mult_b, b1.div_a, b1.div_b} !== 128'h0) begin
      failures++;
      $display("[TB] FAIL reset_operands got=%h %h %h %h exp=0", b1.mult_a, b1.mult_b, b1.div_a, b1.div_b);
    end
    rst = 1'b0;
    repeat (2) step();
    checks++;
    if ({b1.busy, b1.mult_ctrl, b1.div_ctrl, b1.done} !== 4'b0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset got=%b exp=0000", {b1.busy, b1.mult_ctrl, b1.div_ctrl, b1.done});
    end
  endtask

  task automatic test_mult();
    start_op(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    checks++;
    if ({b1.busy, b1.mult_ctrl, b1.div_ctrl} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL mult_launch got=%b exp=110", {b1.busy, b1.mult_ctrl, b1.div_ctrl});
    end
    checks++;
    if ({b1.mult_a, b1.mult_b} !== {32'd7, 32'hFFFF_FFFD}) begin
      failures++;
      $display("[TB] FAIL mult_operands got=%h %h exp=00000007 fffffffd", b1.mult_a, b1.mult_b);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 33) begin
      failures++;
      $display("[TB] FAIL mult_latency got=%0d exp=33", cyc);
    end
    checks++;
    if (b1.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mult_busy_at_done got=%b exp=0", b1.busy);
    end
    checks++;
    if ({b1.hi, b1.lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin
      failures++;
      $display("[TB] FAIL mult_result got=%h_%h exp=ffffffff_ffffffeb", b1.hi, b1.lo);
    end
    step();
    checks++;
    if (b1.done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mult_done_width got=%b exp=0", b1.done);
    end
    checks++;
    if (mult_pulses !== 1 || busy_cycles !== 33) begin
      failures++;
      $display("[TB] FAIL mult_counts got=ctrl%0d busy%0d exp=ctrl1 busy33", mult_pulses, busy_cycles);
    end
  endtask

  task automatic test_back_to_back();
    start_op(OP_MULT, 32'd6, 32'd9);
    wait_done(cyc);
    checks++;
    if (cyc !== 33) begin
      failures++;
      $display("[TB] FAIL b2b_latency got=%0d exp=33", cyc);
    end
    checks++;
    if ({b1.hi, b1.lo} !== {32'h0, 32'd54}) begin
      failures++;
      $display("[TB] FAIL b2b_result got=%h_%h exp=00000000_00000036", b1.hi, b1.lo);
    end
  endtask

  task automatic test_div();
    start_op(OP_DIV, 32'd100, 32'd7);
    checks++;
    if ({b1.busy, b1.mult_ctrl, b1.div_ctrl, b1.div_a, b1.div_b} !== {3'b101, 32'd100, 32'd7}) begin
      failures++;
      $display("[TB] FAIL div_launch got=%b %h %h exp=101 00000064 00000007",
               {b1.busy, b1.mult_ctrl, b1.div_ctrl}, b1.div_a, b1.div_b);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 11) begin
      failures++;
      $display("[TB] FAIL div_latency got=%0d exp=11", cyc);
    end
    checks++;
    if ({b1.hi, b1.lo} !== {32'd2, 32'd14}) begin
      failures++;
      $display("[TB] FAIL div_result got=%h_%h exp=00000002_0000000e", b1.hi, b1.lo);
    end
    step();
    checks++;
    if (div_pulses !== 1 || mult_pulses !== 0) begin
      failures++;
      $display("[TB] FAIL div_pulses got=div%0d mult%0d exp=div1 mult0", div_pulses, mult_pulses);
    end
  endtask

  task automatic test_div_zero();
    start_op(OP_DIV, 32'd5, 32'd0);
    checks++;
    if ({b1.div_zero, b1.busy, b1.div_ctrl} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL dz_pulse got=%b exp=100", {b1.div_zero, b1.busy, b1.div_ctrl});
    end
    step();
    checks++;
    if (b1.div_zero !== 1'b0) begin
      failures++;
      $display("[TB] FAIL dz_width got=%b exp=0", b1.div_zero);
    end
    repeat (3) step();
    checks++;
    if ({b1.hi, b1.lo} !== {32'd2, 32'd14}) begin
      failures++;
      $display("[TB] FAIL dz_hilo_kept got=%h_%h exp=00000002_0000000e", b1.hi, b1.lo);
    end
    checks++;
    if (div_pulses !== 0 || busy_cycles !== 0) begin
      failures++;
      $display("[TB] FAIL dz_no_launch got=div%0d busy%0d exp=div0 busy0", div_pulses, busy_cycles);
    end
  endtask

  task automatic test_hilo_write();
    step();
    b1.hilo_wr = 1'b1; b1.hilo_sel = HILO_HI; b1.hilo_wdata = 32'hAAAA_5555;
    step();
    b1.hilo_wr = 1'b0;
    checks++;
    if ({b1.hi, b1.lo} !== {32'hAAAA_5555, 32'd14}) begin
      failures++;
      $display("[TB] FAIL mthi got=%h_%h exp=aaaa5555_0000000e", b1.hi, b1.lo);
    end
    b1.op_start = 1'b1; b1.op_sel = OP_DIV; b1.rs_val = 32'd100; b1.rt_val = 32'd7;
    b1.hilo_wr = 1'b1; b1.hilo_sel = HILO_LO; b1.hilo_wdata = 32'h11;
    step();
    b1.op_start = 1'b0;
    b1.hilo_wr  = 1'b0;
    checks++;
    if ({b1.busy, b1.lo, b1.div_a} !== {1'b1, 32'h11, 32'd100}) begin
      failures++;
      $display("[TB] FAIL mtlo_with_start got=%b %h %h exp=1 00000011 00000064", b1.busy, b1.lo, b1.div_a);
    end
    wait_done(cyc);
    checks++;
    if ({b1.hi, b1.lo} !== {32'd2, 32'd14}) begin
      failures++;
      $display("[TB] FAIL commit_after_mtlo got=%h_%h exp=00000002_0000000e", b1.hi, b1.lo);
    end
  endtask

  task automatic test_timeout();
    step();
    b2.hilo_wr = 1'b1; b2.hilo_sel = HILO_HI; b2.hilo_wdata = 32'h0000_CAFE;
    step();
    b2.hilo_wr = 1'b0;
    b2.op_start = 1'b1; b2.op_sel = OP_MULT; b2.rs_val = 32'd3; b2.rt_val = 32'd4;
    step();
    b2.op_start = 1'b0;
    checks++;
    if ({b2.busy, b2.mult_ctrl, b2.hi} !== {2'b11, 32'h0000_CAFE}) begin
      failures++;
      $display("[TB] FAIL to_launch got=%b %h exp=11 0000cafe", {b2.busy, b2.mult_ctrl}, b2.hi);
    end
    repeat (2) step();
    b2.hilo_wr = 1'b1; b2.hilo_sel = HILO_LO; b2.hilo_wdata = 32'h1234;
    step();
    b2.hilo_wr = 1'b0;
    checks++;
    if (b2.lo !== 32'h0) begin
      failures++;
      $display("[TB] FAIL mtlo_while_busy got=%h exp=00000000", b2.lo);
    end
    cyc = 3;
    while (!b2.timeout_err && cyc < 100) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc !== 9) begin
      failures++;
      $display("[TB] FAIL to_cycle got=%0d exp=9", cyc);
    end
    checks++;
    if ({b2.busy, b2.done, b2.hi, b2.lo} !== {2'b00, 32'h0000_CAFE, 32'h0}) begin
      failures++;
      $display("[TB] FAIL to_state got=%b %h_%h exp=00 0000cafe_00000000", {b2.busy, b2.done}, b2.hi, b2.lo);
    end
    b2.hilo_wr = 1'b1; b2.hilo_sel = HILO_LO; b2.hilo_wdata = 32'h1234;
    step();
    b2.hilo_wr = 1'b0;
    checks++;
    if ({b2.timeout_err, b2.lo} !== {1'b0, 32'h1234}) begin
      failures++;
      $display("[TB] FAIL mtlo_after_to got=%b %h exp=0 00001234", b2.timeout_err, b2.lo);
    end
  endtask

  task automatic test_reset_mid();
    start_op(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    repeat (9) step();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({b1.busy, b1.mult_a, b1.hi, b1.lo} !== {1'b0, 96'h0}) begin
      failures++;
      $display("[TB] FAIL mid_reset got=%b %h %h_%h exp=0 0 0_0", b1.busy, b1.mult_a, b1.hi, b1.lo);
    end
    step();
    rst = 1'b0;
    step();
    start_op(OP_MULT, 32'd2, 32'd3);
    wait_done(cyc);
    checks++;
    if (cyc !== 33 || {b1.hi, b1.lo} !== {32'h0, 32'd6}) begin
      failures++;
      $display("[TB] FAIL mult_after_reset got=%0d %h_%h exp=33 00000000_00000006", cyc, b1.hi, b1.lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_div_zero();
    test_hilo_write();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
